vpu_cmd_queue: RTL and testbench

Parametrised command front-end between command sources (CPU, SPART, future DMA) and the matrix unit. It buffers complete VPU commands in a FIFO and arbitrates round-robin among NUM_SRC sources. It issues one command at a time to the matrix unit, waiting on its busy handshake. This decouples command producers from VPU latency and replaces the direct `start_VPU` / `VPU_rdy = !busy` coupling.

---
 rtl/vpu_cmd_pkg.sv | 70 +++++++
 rtl/vpu_cmd_fifo.sv | 72 +++++++
 rtl/vpu_cmd_queue.sv | 141 ++++++++++++++
 tb/tb_vpu_cmd_queue.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_cmd_pkg.sv
// Shared definitions for the VPU command queue: command field layout,
// derived command width and issue FSM state encoding.
package vpu_cmd_pkg;

   localparam int unsigned FILL_W      = 1;
   localparam int unsigned OBJ_TYPE_W  = 2;
   localparam int unsigned OBJ_COLOR_W = 3;
   localparam int unsigned OP_W        = 4;
   localparam int unsigned CODE_W      = 4;
   localparam int unsigned OBJ_NUM_W   = 5;
   localparam int unsigned HDR_W       = FILL_W + OBJ_TYPE_W + OBJ_COLOR_W +
                                         OP_W + CODE_W + OBJ_NUM_W;

   // Header fields sit above RO, which sits above V[num_v-1]..V0.
   typedef struct packed {
      logic [FILL_W-1:0]      fill;
      logic [OBJ_TYPE_W-1:0]  obj_type;
      logic [OBJ_COLOR_W-1:0] obj_color;
      logic [OP_W-1:0]        op;
      logic [CODE_W-1:0]      code;
      logic [OBJ_NUM_W-1:0]   obj_num;
   } cmd_hdr_t;

   function automatic int unsigned cmd_width(input int unsigned num_v,
                                             input int unsigned vw);
      return HDR_W + (num_v + 1) * vw;
   endfunction

   function automatic int unsigned vertex_lsb(input int unsigned idx,
                                              input int unsigned vw);
      return idx * vw;
   endfunction

   function automatic int unsigned ro_lsb(input int unsigned num_v,
                                          input int unsigned vw);
      return num_v * vw;
   endfunction

   function automatic int unsigned obj_num_lsb(input int unsigned num_v,
                                               input int unsigned vw);
      return (num_v + 1) * vw;
   endfunction

   function automatic int unsigned code_lsb(input int unsigned num_v,
                                            input int unsigned vw);
      return obj_num_lsb(num_v, vw) + OBJ_NUM_W;
   endfunction

   function automatic int unsigned op_lsb(input int unsigned num_v,
                                          input int unsigned vw);
      return code_lsb(num_v, vw) + CODE_W;
   endfunction

   function automatic int unsigned obj_color_lsb(input int unsigned num_v,
                                                 input int unsigned vw);
      return op_lsb(num_v, vw) + OP_W;
   endfunction

   function automatic int unsigned obj_type_lsb(input int unsigned num_v,
                                                input int unsigned vw);
      return obj_color_lsb(num_v, vw) + OBJ_COLOR_W;
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_ACK  = 2'd1,
      ST_WAIT_DONE = 2'd2
   } issue_state_t;

endpackage

// File: rtl/vpu_cmd_fifo.sv
// Synchronous command FIFO with occupancy count, flush and a registered
// read port that only updates on pop.
module vpu_cmd_fifo
   import vpu_cmd_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CMD_W = 163
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [CMD_W-1:0]           push_data,
   input  logic                       pop,
   input  logic                       flush,
   output logic [CMD_W-1:0]           rd_data,
   output logic [$clog2(DEPTH+1)-1:0] occupancy,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned OW = $clog2(DEPTH + 1);

   logic [CMD_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (occupancy == OW'(DEPTH));
   assign empty   = (occupancy == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // A pop concurrent with flush still delivers its entry; the read pointer
   // then jumps to the write pointer so nothing else remains visible.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
         rd_data   <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_data <= mem[rd_ptr];
         end
         if (flush) begin
            rd_ptr    <= wr_ptr;
            occupancy <= '0;
         end else begin
            if (do_pop) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
               2'b10:   occupancy <= occupancy + 1'b1;
               2'b01:   occupancy <= occupancy - 1'b1;
               default: occupancy <= occupancy;
            endcase
         end
      end
   end

endmodule

// File: rtl/vpu_cmd_queue.sv
// VPU command front-end: round-robin arbitration among command sources into
// a FIFO, and one-at-a-time issue to the matrix unit on its busy handshake.
module vpu_cmd_queue
   import vpu_cmd_pkg::*;
#(
   parameter int unsigned NUM_SRC     = 2,
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned VW          = 16,
   parameter int unsigned NUM_V       = 8,
   parameter int unsigned ACK_TIMEOUT = 4,
   parameter int unsigned CMD_W       = cmd_width(NUM_V, VW)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_SRC-1:0]         src_start,
   input  logic [NUM_SRC*CMD_W-1:0]   src_cmd,
   output logic [NUM_SRC-1:0]         src_ack,
   input  logic                       flush,
   input  logic                       vpu_busy,
   output logic                       go,
   output logic [CMD_W-1:0]           cmd_out,
   output logic [$clog2(DEPTH+1)-1:0] occupancy,
   output logic                       full,
   output logic                       empty,
   output logic                       timeout_err
);

   localparam int unsigned SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

   logic [SW-1:0]    rr_ptr;
   logic [SW-1:0]    grant_idx;
   logic             grant_vld;
   logic [CMD_W-1:0] push_data;
   logic             pop;
   issue_state_t     state;
   logic [TW-1:0]    to_cnt;

   // Search starts at rr_ptr and wraps; ack is held off while full or
   // flushing so a grant is always an accept.
   always_comb begin
      int unsigned s;
      s         = 0;
      src_ack   = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      if (rst_n && !full && !flush) begin
         for (int unsigned i = 0; i < NUM_SRC; i++) begin
            s = int'(rr_ptr) + i;
            if (s >= NUM_SRC) begin
               s = s - NUM_SRC;
            end
            if (!grant_vld && src_start[SW'(s)]) begin
               grant_vld = 1'b1;
               grant_idx = SW'(s);
            end
         end
      end
      if (grant_vld) begin
         src_ack[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      push_data = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (grant_idx == SW'(i)) begin
            push_data = src_cmd[i*CMD_W +: CMD_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (grant_vld) begin
         if (grant_idx == SW'(NUM_SRC - 1)) begin
            rr_ptr <= '0;
         end else begin
            rr_ptr <= grant_idx + 1'b1;
         end
      end
   end

   assign pop = (state == ST_IDLE) && !empty && !vpu_busy;

   // The go cycle itself is not counted toward the ack timeout: the matrix
   // unit cannot respond to go until the following cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         go          <= 1'b0;
         to_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         go <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  go     <= 1'b1;
                  to_cnt <= '0;
                  state  <= ST_WAIT_ACK;
               end
            end
            ST_WAIT_ACK: begin
               if (vpu_busy) begin
                  state <= ST_WAIT_DONE;
               end else if (to_cnt == TW'(ACK_TIMEOUT)) begin
                  timeout_err <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            ST_WAIT_DONE: begin
               if (!vpu_busy) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   vpu_cmd_fifo #(
      .DEPTH (DEPTH),
      .CMD_W (CMD_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (grant_vld),
      .push_data (push_data),
      .pop       (pop),
      .flush     (flush),
      .rd_data   (cmd_out),
      .occupancy (occupancy),
      .full      (full),
      .empty     (empty)
   );

endmodule

// File: tb/tb_vpu_cmd_queue.sv
// Self-checking bench for vpu_cmd_queue: directed table and sequences, then
// randomized traffic against a queue-based reference model.
module tb_vpu_cmd_queue;

   localparam int unsigned NUM_SRC     = 2;
   localparam int unsigned DEPTH       = 8;
   localparam int unsigned VW          = 16;
   localparam int unsigned NUM_V       = 8;
   localparam int unsigned ACK_TIMEOUT = 4;
   localparam int unsigned CMD_W       = 19 + (NUM_V + 1) * VW;

   typedef logic [CMD_W-1:0] cmd_t;

   logic                       clk = 1'b0;
   logic                       rst_n = 1'b0;
   logic [NUM_SRC-1:0]         src_start = '0;
   logic [NUM_SRC*CMD_W-1:0]   src_cmd = '0;
   logic [NUM_SRC-1:0]         src_ack;
   logic                       flush = 1'b0;
   logic                       vpu_busy = 1'b0;
   logic                       go;
   cmd_t                       cmd_out;
   logic [$clog2(DEPTH+1)-1:0] occupancy;
   logic                       full;
   logic                       empty;
   logic                       timeout_err;

   always #5 clk = ~clk;

   vpu_cmd_queue #(
      .NUM_SRC     (NUM_SRC),
      .DEPTH       (DEPTH),
      .VW          (VW),
      .NUM_V       (NUM_V),
      .ACK_TIMEOUT (ACK_TIMEOUT),
      .CMD_W       (CMD_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .src_start   (src_start),
      .src_cmd     (src_cmd),
      .src_ack     (src_ack),
      .flush       (flush),
      .vpu_busy    (vpu_busy),
      .go          (go),
      .cmd_out     (cmd_out),
      .occupancy   (occupancy),
      .full        (full),
      .empty       (empty),
      .timeout_err (timeout_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input cmd_t act, input cmd_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int s, input cmd_t c);
      src_cmd[s*CMD_W +: CMD_W] = c;
   endtask

   function automatic cmd_t get_src(input int s);
      return src_cmd[s*CMD_W +: CMD_W];
   endfunction

   // Field order MSB->LSB: fill, obj_type, obj_color, op, code, obj_num, RO, V7..V0
   function automatic cmd_t make_cmd(input logic [1:0] ot, input logic [2:0] oc,
                                     input logic [3:0] op, input logic [3:0] code,
                                     input logic [4:0] num, input logic [15:0] ro,
                                     input logic [15:0] v0, input logic [15:0] vstep);
      logic [NUM_V*VW-1:0] vx;
      for (int i = 0; i < NUM_V; i++) vx[i*VW +: VW] = v0 + 16'(i) * vstep;
      return {1'b0, ot, oc, op, code, num, ro, vx};
   endfunction

   function automatic cmd_t rand_cmd();
      logic [191:0] t;
      for (int w = 0; w < 6; w++) t[w*32 +: 32] = $urandom();
      return t[CMD_W-1:0];
   endfunction

   typedef struct {
      int          src;
      logic [1:0]  ot;
      logic [2:0]  oc;
      logic [3:0]  op;
      logic [3:0]  code;
      logic [4:0]  num;
      logic [15:0] ro;
      logic [15:0] v0;
      int          busy_len;
      int          exp_occ;
   } vec_t;

   vec_t tbl[4];

   // Reference model state for the randomized phase
   cmd_t mq[$];
   int   rr = 0;
   bit   outstanding = 1'b0;
   bit   seen_busy = 1'b0;
   cmd_t last_cmd = '0;
   bit   bfm_active = 1'b0;
   int   bfm_dly = 0;
   int   bfm_hold = 0;

   task automatic rand_step(input bit traffic);
      logic [NUM_SRC-1:0] exp_ack;
      int   gsrc;
      bit   exp_go;
      bit   busy_pre;
      bit   flush_pre;
      cmd_t acc_cmd;
      cmd_t exp_c;
      #1;
      exp_ack = '0;
      gsrc    = -1;
      acc_cmd = '0;
      if (!flush && mq.size() < DEPTH) begin
         for (int k = 0; k < NUM_SRC; k++) begin
            int s;
            s = (rr + k) % NUM_SRC;
            if (gsrc < 0 && src_start[s]) gsrc = s;
         end
      end
      if (gsrc >= 0) begin
         exp_ack[gsrc] = 1'b1;
         acc_cmd = get_src(gsrc);
      end
      chk("rnd_ack", cmd_t'(src_ack), cmd_t'(exp_ack));
      exp_go    = !outstanding && mq.size() > 0 && !vpu_busy;
      busy_pre  = vpu_busy;
      flush_pre = flush;
      tick();
      chk("rnd_go", cmd_t'(go), cmd_t'(exp_go));
      if (exp_go) begin
         exp_c = mq.pop_front();
         chk("rnd_cmd", cmd_out, exp_c);
         last_cmd = exp_c;
      end else begin
         chk("rnd_cmd_hold", cmd_out, last_cmd);
      end
      if (outstanding && seen_busy && !busy_pre) outstanding = 1'b0;
      else if (outstanding && busy_pre) seen_busy = 1'b1;
      if (exp_go) begin
         outstanding = 1'b1;
         seen_busy   = 1'b0;
      end
      if (flush_pre) mq.delete();
      if (gsrc >= 0) begin
         mq.push_back(acc_cmd);
         src_start[gsrc] = 1'b0;
         rr = (gsrc + 1) % NUM_SRC;
      end
      chk("rnd_occ", cmd_t'(occupancy), cmd_t'(mq.size()));
      chk("rnd_full", cmd_t'(full), cmd_t'(mq.size() == DEPTH));
      chk("rnd_empty", cmd_t'(empty), cmd_t'(mq.size() == 0));
      // Matrix unit: acknowledges within 0..2 cycles, busy for 1..4 cycles
      if (go) begin
         bfm_active = 1'b1;
         bfm_dly    = $urandom_range(0, 2);
         bfm_hold   = $urandom_range(1, 4);
      end
      if (bfm_active) begin
         if (bfm_dly > 0) begin
            vpu_busy = 1'b0;
            bfm_dly--;
         end else if (bfm_hold > 0) begin
            vpu_busy = 1'b1;
            bfm_hold--;
         end else begin
            vpu_busy   = 1'b0;
            bfm_active = 1'b0;
         end
      end
      flush = traffic && ($urandom_range(0, 99) < 3);
      for (int s = 0; s < NUM_SRC; s++) begin
         if (traffic && !src_start[s] && $urandom_range(0, 99) < 40) begin
            set_src(s, rand_cmd());
            src_start[s] = 1'b1;
         end
      end
   endtask

   task automatic wait_go(input int limit, output bit seen);
      seen = 1'b0;
      for (int k = 0; k < limit; k++) begin
         tick();
         if (go) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic [NUM_SRC-1:0] oh;
      cmd_t c, ca, cb, third;
      cmd_t fill_q[$];
      int   exp_src;
      bit   seen;

      tbl[0] = '{0, 2'd0, 3'd0, 4'h1, 4'h0, 5'd3,  16'h0000, 16'h0010, 2, 1};
      tbl[1] = '{1, 2'd3, 3'd5, 4'hA, 4'h7, 5'd31, 16'hBEEF, 16'hFFFF, 1, 1};
      tbl[2] = '{0, 2'd1, 3'd7, 4'hF, 4'hF, 5'd0,  16'hFFFF, 16'h0000, 3, 1};
      tbl[3] = '{1, 2'd2, 3'd2, 4'h4, 4'h9, 5'd17, 16'h1234, 16'h8001, 2, 1};

      // Reset values
      rst_n = 1'b0;
      repeat (2) tick();
      chk("rst_ack", cmd_t'(src_ack), '0);
      chk("rst_go", cmd_t'(go), '0);
      chk("rst_cmd", cmd_out, '0);
      chk("rst_occ", cmd_t'(occupancy), '0);
      chk("rst_full", cmd_t'(full), '0);
      chk("rst_empty", cmd_t'(empty), cmd_t'(1));
      chk("rst_to", cmd_t'(timeout_err), '0);
      rst_n = 1'b1;
      tick();

      // Single-command latency: accept at edge N, go after edge N+1
      foreach (tbl[i]) begin
         c = make_cmd(tbl[i].ot, tbl[i].oc, tbl[i].op, tbl[i].code, tbl[i].num,
                      tbl[i].ro, tbl[i].v0, 16'h0101);
         set_src(tbl[i].src, c);
         src_start = '0;
         src_start[tbl[i].src] = 1'b1;
         oh = '0;
         oh[tbl[i].src] = 1'b1;
         #1;
         chk("tbl_ack", cmd_t'(src_ack), cmd_t'(oh));
         tick();
         src_start = '0;
         chk("tbl_occ_acc", cmd_t'(occupancy), cmd_t'(tbl[i].exp_occ));
         chk("tbl_go_early", cmd_t'(go), '0);
         tick();
         chk("tbl_go", cmd_t'(go), cmd_t'(1));
         chk("tbl_cmd", cmd_out, c);
         chk("tbl_occ_issue", cmd_t'(occupancy), '0);
         vpu_busy = 1'b1;
         tick();
         chk("tbl_go_pulse", cmd_t'(go), '0);
         repeat (tbl[i].busy_len - 1) tick();
         vpu_busy = 1'b0;
         repeat (2) tick();
         chk("tbl_cmd_hold", cmd_out, c);
      end

      // Fill with matrix stuck busy: grants alternate, full after DEPTH accepts
      vpu_busy  = 1'b1;
      set_src(0, rand_cmd());
      set_src(1, rand_cmd());
      src_start = '1;
      exp_src   = 0;
      for (int k = 0; k < DEPTH; k++) begin
         #1;
         oh = '0;
         oh[exp_src] = 1'b1;
         chk("fill_ack", cmd_t'(src_ack), cmd_t'(oh));
         fill_q.push_back(get_src(exp_src));
         tick();
         set_src(exp_src, rand_cmd());
         exp_src = (exp_src + 1) % NUM_SRC;
      end
      #1;
      chk("fill_full", cmd_t'(full), cmd_t'(1));
      chk("fill_occ", cmd_t'(occupancy), cmd_t'(DEPTH));
      chk("fill_ack_off", cmd_t'(src_ack), '0);
      chk("fill_no_go", cmd_t'(go), '0);

      // Busy drops: the pop in the full cycle must not re-enable ack
      vpu_busy = 1'b0;
      #1;
      chk("full_pop_ack", cmd_t'(src_ack), '0);
      tick();
      src_start = '0;
      chk("drain_go", cmd_t'(go), cmd_t'(1));
      chk("drain_cmd", cmd_out, fill_q.pop_front());
      chk("drain_occ", cmd_t'(occupancy), cmd_t'(DEPTH - 1));
      for (int k = 0; k < 2; k++) begin
         vpu_busy = 1'b1;
         repeat (5) begin
            tick();
            chk("drain_busy_no_go", cmd_t'(go), '0);
         end
         vpu_busy = 1'b0;
         tick();
         chk("drain_gap", cmd_t'(go), '0);
         tick();
         chk("drain_go_2cyc", cmd_t'(go), cmd_t'(1));
         third = fill_q.pop_front();
         chk("drain_order", cmd_out, third);
      end
      chk("pre_flush_occ", cmd_t'(occupancy), cmd_t'(5));

      // Flush while the third command sits in WAIT_DONE
      vpu_busy = 1'b1;
      repeat (2) tick();
      flush = 1'b1;
      set_src(0, rand_cmd());
      src_start = 2'b01;
      #1;
      chk("flush_ack", cmd_t'(src_ack), '0);
      tick();
      flush = 1'b0;
      src_start = '0;
      chk("flush_occ", cmd_t'(occupancy), '0);
      chk("flush_empty", cmd_t'(empty), cmd_t'(1));
      repeat (2) tick();
      vpu_busy = 1'b0;
      repeat (8) begin
         tick();
         chk("flush_no_go", cmd_t'(go), '0);
      end
      chk("flush_cmd_hold", cmd_out, third);

      // Ack timeout: busy never rises, timeout five cycles after go
      ca = rand_cmd();
      cb = rand_cmd();
      set_src(0, ca);
      src_start = 2'b01;
      tick();
      set_src(0, cb);
      tick();
      src_start = '0;
      chk("to_go", cmd_t'(go), cmd_t'(1));
      chk("to_cmd", cmd_out, ca);
      repeat (4) begin
         tick();
         chk("to_early", cmd_t'(timeout_err), '0);
      end
      tick();
      chk("to_set", cmd_t'(timeout_err), cmd_t'(1));
      wait_go(4, seen);
      chk("to_next_go", cmd_t'(seen), cmd_t'(1));
      chk("to_next_cmd", cmd_out, cb);
      vpu_busy = 1'b1;
      tick();
      vpu_busy = 1'b0;
      repeat (2) tick();
      chk("to_sticky", cmd_t'(timeout_err), cmd_t'(1));

      // Reset with three queued entries and a command in WAIT_DONE
      set_src(0, rand_cmd());
      src_start = 2'b01;
      tick();
      src_start = '0;
      wait_go(4, seen);
      chk("rr_go", cmd_t'(seen), cmd_t'(1));
      vpu_busy = 1'b1;
      tick();
      src_start = 2'b01;
      repeat (3) begin
         tick();
         set_src(0, rand_cmd());
      end
      src_start = '0;
      chk("rr_occ", cmd_t'(occupancy), cmd_t'(3));
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      vpu_busy = 1'b0;
      chk("rr_ack", cmd_t'(src_ack), '0);
      chk("rr_go_low", cmd_t'(go), '0);
      chk("rr_cmd", cmd_out, '0);
      chk("rr_occ0", cmd_t'(occupancy), '0);
      chk("rr_full", cmd_t'(full), '0);
      chk("rr_empty", cmd_t'(empty), cmd_t'(1));
      chk("rr_to", cmd_t'(timeout_err), '0);
      repeat (5) begin
         tick();
         chk("rr_no_go", cmd_t'(go), '0);
      end

      // Randomized traffic against the reference model
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      mq.delete();
      rr = 0;
      outstanding = 1'b0;
      seen_busy = 1'b0;
      last_cmd = '0;
      repeat (1500) rand_step(1'b1);
      flush = 1'b0;
      src_start = '0;
      repeat (150) rand_step(1'b0);
      chk("rnd_drained", cmd_t'(occupancy), '0);
      chk("rnd_no_timeout", cmd_t'(timeout_err), '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
